// File: rtl/operand_loader.sv
// Serial-to-parallel operand loader: assembles two LSB-first bit streams into
// parallel words and holds them under a valid/ack handshake.
module operand_loader #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         bit_valid,
    input  logic         bit_a,
    input  logic         bit_b,
    input  logic         word_ack,
    output logic [N-1:0] word_a,
    output logic [N-1:0] word_b,
    output logic         word_valid,
    output logic         busy
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, PRESENT} state_t;

    state_t        state_reg;
    logic [N-1:0]  sh_a_reg, sh_b_reg;
    logic [N-1:0]  sh_a_next, sh_b_next;
    logic [CW-1:0] cnt_reg;

    // New bits enter at the MSB so the first received bit ends up at bit 0.
    generate
        if (N == 1) begin : g_single
            assign sh_a_next = bit_a;
            assign sh_b_next = bit_b;
        end else begin : g_multi
            assign sh_a_next = {bit_a, sh_a_reg[N-1:1]};
            assign sh_b_next = {bit_b, sh_b_reg[N-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            sh_a_reg   <= '0;
            sh_b_reg   <= '0;
            cnt_reg    <= '0;
            word_a     <= '0;
            word_b     <= '0;
            word_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        sh_a_reg  <= '0;
                        sh_b_reg  <= '0;
                        cnt_reg   <= '0;
                        busy      <= 1'b1;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_valid) begin
                        sh_a_reg <= sh_a_next;
                        sh_b_reg <= sh_b_next;
                        cnt_reg  <= cnt_reg + CW'(1);
                        // Output words update only here, so they keep the
                        // previous pair throughout a load.
                        if (cnt_reg == LAST) begin
                            word_a     <= sh_a_next;
                            word_b     <= sh_b_next;
                            word_valid <= 1'b1;
                            state_reg  <= PRESENT;
                        end
                    end
                end
                PRESENT: begin
                    if (word_ack) begin
                        word_valid <= 1'b0;
                        busy       <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    word_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader: N=3 and N=1 instances, directed vectors.
module tb_operand_loader;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0, bit_valid = 1'b0, bit_a = 1'b0, bit_b = 1'b0, word_ack = 1'b0;
    logic [2:0] word_a, word_b;
    logic       word_valid, busy;
    logic       start1 = 1'b0, bit_valid1 = 1'b0, bit_a1 = 1'b0, bit_b1 = 1'b0, word_ack1 = 1'b0;
    logic [0:0] word_a1, word_b1;
    logic       word_valid1, busy1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0;

    logic [5:0] exp_q[$];
    logic [1:0] exp_q1[$];
    logic       prev_valid = 1'b0, prev_valid1 = 1'b0;

    always #5 clk = ~clk;

    operand_loader #(.N(3)) dut (
        .clk(clk), .reset(reset), .start(start), .bit_valid(bit_valid),
        .bit_a(bit_a), .bit_b(bit_b), .word_ack(word_ack),
        .word_a(word_a), .word_b(word_b), .word_valid(word_valid), .busy(busy)
    );

    operand_loader #(.N(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .bit_valid(bit_valid1),
        .bit_a(bit_a1), .bit_b(bit_b1), .word_ack(word_ack1),
        .word_a(word_a1), .word_b(word_b1), .word_valid(word_valid1), .busy(busy1)
    );

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end else begin
            $display("[TB] ok   %s = %0d (cycle %0d)", name, actual, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic start_load();
        t0 = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic a, input logic b);
        bit_valid = 1'b1;
        bit_a = a;
        bit_b = b;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic ack();
        word_ack = 1'b1;
        tick();
        word_ack = 1'b0;
    endtask

    // Monitors: compare each new presentation against the scoreboard.
    always @(negedge clk) begin
        if (word_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL sb3_unexpected: got a=%0d b=%0d, expected no presentation", word_a, word_b);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                check("sb3_word_a", word_a, e[5:3]);
                check("sb3_word_b", word_b, e[2:0]);
            end
        end
        prev_valid = word_valid;
    end

    always @(negedge clk) begin
        if (word_valid1 && !prev_valid1) begin
            if (exp_q1.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL sb1_unexpected: got a=%0d b=%0d, expected no presentation", word_a1, word_b1);
            end else begin
                logic [1:0] e;
                e = exp_q1.pop_front();
                check("sb1_word_a", word_a1, e[1]);
                check("sb1_word_b", word_b1, e[0]);
            end
        end
        prev_valid1 = word_valid1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_word_a", word_a, 0);
        check("rst_word_b", word_b, 0);
        check("rst_valid", word_valid, 0);
        check("rst_busy", busy, 0);

        // Basic load: A=5, B=3
        exp_q.push_back({3'd5, 3'd3});
        start_load();
        check("basic_busy", busy, 1);
        beat(1, 1);
        check("basic_valid_b1", word_valid, 0);
        beat(0, 1);
        check("basic_valid_b2", word_valid, 0);
        beat(1, 0);
        check("basic_valid", word_valid, 1);
        check("basic_latency", cyc - t0, 4);
        idle(2);
        check("basic_hold_a", word_a, 5);
        check("basic_hold_b", word_b, 3);
        check("basic_hold_valid", word_valid, 1);
        ack();
        check("basic_ack_valid", word_valid, 0);
        check("basic_ack_busy", busy, 0);

        // Same stream with two 2-cycle stalls
        exp_q.push_back({3'd5, 3'd3});
        start_load();
        beat(1, 1);
        idle(2);
        check("stall_prev_a", word_a, 5);
        check("stall_prev_b", word_b, 3);
        check("stall_valid", word_valid, 0);
        beat(0, 1);
        idle(2);
        beat(1, 0);
        check("stall_latency", cyc - t0, 8);
        check("stall_valid_end", word_valid, 1);
        ack();

        // start mid-SHIFT ignored: A=6, B=1
        exp_q.push_back({3'd6, 3'd1});
        start_load();
        beat(0, 1);
        start = 1'b1;
        beat(1, 0);
        start = 1'b0;
        check("midstart_busy", busy, 1);
        beat(1, 0);
        check("midstart_latency", cyc - t0, 4);
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            bit_valid = 1'b1;
            bit_a = 1'($urandom_range(0, 1));
            bit_b = 1'($urandom_range(0, 1));
            tick();
        end
        start = 1'b0;
        bit_valid = 1'b0;
        check("present_freeze_a", word_a, 6);
        check("present_freeze_b", word_b, 1);
        check("present_freeze_valid", word_valid, 1);
        ack();
        ack();
        check("idle_ack_busy", busy, 0);
        check("idle_ack_valid", word_valid, 0);
        check("idle_ack_a", word_a, 6);
        check("idle_ack_b", word_b, 1);

        // Reset mid-SHIFT, then load A=7, B=0
        start_load();
        beat(1, 1);
        beat(1, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_shift_a", word_a, 0);
        check("rst_shift_b", word_b, 0);
        check("rst_shift_busy", busy, 0);
        idle(3);
        check("rst_shift_idle_valid", word_valid, 0);
        exp_q.push_back({3'd7, 3'd0});
        start_load();
        beat(1, 0);
        beat(1, 0);
        beat(1, 0);
        check("after_rst_valid", word_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_present_valid", word_valid, 0);
        check("rst_present_busy", busy, 0);

        // Back-to-back: A=1,B=2 then ack+start together, then A=2,B=6
        exp_q.push_back({3'd1, 3'd2});
        start_load();
        beat(1, 0);
        beat(0, 1);
        beat(0, 0);
        word_ack = 1'b1;
        start = 1'b1;
        tick();
        word_ack = 1'b0;
        start = 1'b0;
        check("b2b_valid", word_valid, 0);
        check("b2b_busy", busy, 0);
        exp_q.push_back({3'd2, 3'd6});
        start_load();
        beat(0, 0);
        beat(1, 1);
        beat(0, 1);
        check("b2b_latency", cyc - t0, 4);
        check("b2b_valid2", word_valid, 1);
        ack();

        // N=1 instance: single beat (1,0)
        exp_q1.push_back(2'b10);
        check("n1_busy_idle", busy1, 0);
        t0 = cyc;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("n1_busy", busy1, 1);
        check("n1_valid_early", word_valid1, 0);
        bit_valid1 = 1'b1;
        bit_a1 = 1'b1;
        bit_b1 = 1'b0;
        tick();
        bit_valid1 = 1'b0;
        check("n1_valid", word_valid1, 1);
        check("n1_latency", cyc - t0, 2);
        word_ack1 = 1'b1;
        tick();
        word_ack1 = 1'b0;
        check("n1_ack_valid", word_valid1, 0);

        idle(2);
        check("sb3_drained", exp_q.size(), 0);
        check("sb1_drained", exp_q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
